vga_sink: RTL

Receiving end of the VGA output: samples the VGA_HS/VGA_VS/VGA_BLANK_N/VGA_CLK/RGB stream driven by the display pipeline in the same 50 MHz domain. It recovers pixel coordinates, checks 640x480 timing, and locks onto the stream. It also computes a per-frame checksum so on-chip self-test and benches can verify display content without an external monitor.

---
 rtl/vga_sink_pkg.sv | 33 +++
 rtl/vga_sink_if.sv | 18 +
 rtl/vga_edge_sampler.sv | 50 +++++
 rtl/vga_sink.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/vga_sink_pkg.sv
// Shared VGA sink types, 640x480 timing defaults and small helpers.
// Also consumed by the timing generator so both ends agree on the frame geometry.
package vga_sink_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam int unsigned ERR_H_TOTAL = 0;
    localparam int unsigned ERR_V_TOTAL = 1;
    localparam int unsigned ERR_ACTIVE  = 2;

    localparam int unsigned H_ACTIVE_DEF    = 640;
    localparam int unsigned H_TOTAL_DEF     = 800;
    localparam int unsigned V_ACTIVE_DEF    = 480;
    localparam int unsigned V_TOTAL_DEF     = 525;
    localparam int unsigned LOCK_FRAMES_DEF = 2;

    localparam int unsigned CNT_W = 11;
    typedef logic [CNT_W-1:0] cnt_t;

    // Timing counters stick at all-ones so a missing sync can never alias a good count.
    function automatic cnt_t sat_inc(input cnt_t v);
        return (v == '1) ? v : v + cnt_t'(1);
    endfunction

    function automatic logic [31:0] sum_step(input logic [31:0] s, input logic [23:0] rgb);
        return {s[30:0], s[31]} ^ {8'h00, rgb};
    endfunction

endpackage

// File: rtl/vga_sink_if.sv
// VGA pin bundle between the display pipeline (master) and the sink (slave).
interface vga_sink_if;
    logic       VGA_CLK;
    logic       VGA_HS;
    logic       VGA_VS;
    logic       VGA_BLANK_N;
    logic [7:0] VGA_R;
    logic [7:0] VGA_G;
    logic [7:0] VGA_B;

    modport master (
        output VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B
    );

    modport slave (
        input VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B
    );
endinterface

// File: rtl/vga_edge_sampler.sv
// Registers the VGA pins once and derives pixel strobe and sync/blank edge pulses.
module vga_edge_sampler (
    input  logic        clk,
    input  logic        reset,
    vga_sink_if.slave   vga,
    output logic [23:0] rgb,
    output logic        blank,
    output logic        strobe,
    output logic        hs_fall,
    output logic        vs_fall,
    output logic        blank_rise,
    output logic        blank_fall
);
    logic s_clk, s_hs, s_vs, s_blank;
    logic d_clk, d_hs, d_vs, d_blank;
    logic [23:0] s_rgb;

    // Reset to 0 so the first sample after reset can only show rising syncs, never a false fall.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_clk   <= 1'b0;
            s_hs    <= 1'b0;
            s_vs    <= 1'b0;
            s_blank <= 1'b0;
            s_rgb   <= '0;
            d_clk   <= 1'b0;
            d_hs    <= 1'b0;
            d_vs    <= 1'b0;
            d_blank <= 1'b0;
        end else begin
            s_clk   <= vga.VGA_CLK;
            s_hs    <= vga.VGA_HS;
            s_vs    <= vga.VGA_VS;
            s_blank <= vga.VGA_BLANK_N;
            s_rgb   <= {vga.VGA_R, vga.VGA_G, vga.VGA_B};
            d_clk   <= s_clk;
            d_hs    <= s_hs;
            d_vs    <= s_vs;
            d_blank <= s_blank;
        end
    end

    assign rgb        = s_rgb;
    assign blank      = s_blank;
    assign strobe     = s_clk & ~d_clk;
    assign hs_fall    = ~s_hs & d_hs;
    assign vs_fall    = ~s_vs & d_vs;
    assign blank_rise = s_blank & ~d_blank;
    assign blank_fall = ~s_blank & d_blank;
endmodule

// File: rtl/vga_sink.sv
// VGA receiver: recovers pixel coordinates, checks frame timing and locks onto the stream.
// Define VGA_SINK_CHECKSUM_EN to build the per-frame rotate/xor checksum; otherwise frame_sum is 0.
module vga_sink
    import vga_sink_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = H_ACTIVE_DEF,
    parameter int unsigned H_TOTAL     = H_TOTAL_DEF,
    parameter int unsigned V_ACTIVE    = V_ACTIVE_DEF,
    parameter int unsigned V_TOTAL     = V_TOTAL_DEF,
    parameter int unsigned LOCK_FRAMES = LOCK_FRAMES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    vga_sink_if.slave   vga,
    input  logic        err_clr,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [23:0] pix_rgb,
    output logic        frame_done,
    output logic [31:0] frame_sum,
    output logic        locked,
    output logic [2:0]  err
);
    localparam cnt_t       H_ACTIVE_C = cnt_t'(H_ACTIVE);
    localparam cnt_t       H_TOTAL_C  = cnt_t'(H_TOTAL);
    localparam cnt_t       V_ACTIVE_C = cnt_t'(V_ACTIVE);
    localparam cnt_t       V_TOTAL_C  = cnt_t'(V_TOTAL);
    localparam logic [7:0] LOCK_C     = 8'(LOCK_FRAMES);

    logic [23:0] rgb;
    logic        blank, strobe, hs_fall, vs_fall, blank_rise, blank_fall;

    vga_edge_sampler u_sampler (
        .clk        (clk),
        .reset      (reset),
        .vga        (vga),
        .rgb        (rgb),
        .blank      (blank),
        .strobe     (strobe),
        .hs_fall    (hs_fall),
        .vs_fall    (vs_fall),
        .blank_rise (blank_rise),
        .blank_fall (blank_fall)
    );

    state_t     state, state_nxt;
    cnt_t       h_cnt, a_cnt, v_cnt, av_cnt;
    logic [9:0] x_cnt, y_cnt, x_cur;
    logic [7:0] good_cnt, good_inc;
    logic       first_hs, frame_bad, chk_en, enter_measure;
    logic       h_bad, a_bad, v_bad, av_bad, fail, done_now, act_strobe;
    logic [2:0] err_set;

    assign act_strobe    = strobe & blank;
    assign enter_measure = (state == SEARCH) & vs_fall;
    assign good_inc      = good_cnt + 8'd1;
    assign x_cur         = blank_rise ? '0 : x_cnt;

    assign h_bad  = chk_en & hs_fall & ~first_hs & (h_cnt != H_TOTAL_C);
    assign a_bad  = chk_en & blank_fall & (a_cnt != H_ACTIVE_C);
    assign v_bad  = chk_en & vs_fall & (v_cnt != V_TOTAL_C);
    assign av_bad = chk_en & vs_fall & (av_cnt != V_ACTIVE_C);
    assign fail   = h_bad | a_bad | v_bad | av_bad;

    assign done_now = locked & vs_fall & ~fail;

    always_comb begin
        err_set              = '0;
        err_set[ERR_H_TOTAL] = h_bad;
        err_set[ERR_V_TOTAL] = v_bad;
        err_set[ERR_ACTIVE]  = a_bad | av_bad;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= SEARCH;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            SEARCH:  if (vs_fall) state_nxt = MEASURE;
            MEASURE: if (vs_fall && !fail && !frame_bad && good_inc == LOCK_C) state_nxt = LOCKED;
            LOCKED:  if (fail) state_nxt = SEARCH;
            default: state_nxt = SEARCH;
        endcase
    end

    always_comb begin
        locked = 1'b0;
        chk_en = 1'b0;
        unique case (state)
            MEASURE: chk_en = 1'b1;
            LOCKED: begin
                locked = 1'b1;
                chk_en = 1'b1;
            end
            default: ;
        endcase
    end

    // A strobe that coincides with the restarting edge belongs to the new line/frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt  <= '0;
            a_cnt  <= '0;
            v_cnt  <= '0;
            av_cnt <= '0;
            x_cnt  <= '0;
            y_cnt  <= '0;
        end else begin
            if (hs_fall || enter_measure) h_cnt <= strobe ? cnt_t'(1) : '0;
            else if (strobe)              h_cnt <= sat_inc(h_cnt);

            if (hs_fall || enter_measure) a_cnt <= act_strobe ? cnt_t'(1) : '0;
            else if (act_strobe)          a_cnt <= sat_inc(a_cnt);

            if (vs_fall)      v_cnt <= hs_fall ? cnt_t'(1) : '0;
            else if (hs_fall) v_cnt <= sat_inc(v_cnt);

            if (vs_fall)         av_cnt <= blank_fall ? cnt_t'(1) : '0;
            else if (blank_fall) av_cnt <= sat_inc(av_cnt);

            if (act_strobe)      x_cnt <= x_cur + 10'd1;
            else if (blank_rise) x_cnt <= '0;

            if (vs_fall)         y_cnt <= '0;
            else if (blank_fall) y_cnt <= y_cnt + 10'd1;
        end
    end

    // A failure on the closing VS edge condemns the old frame, so the new one starts clean.
    always_ff @(posedge clk) begin
        if (reset) begin
            good_cnt  <= '0;
            frame_bad <= 1'b0;
            first_hs  <= 1'b0;
        end else begin
            if (enter_measure) first_hs <= 1'b1;
            else if (hs_fall)  first_hs <= 1'b0;

            if (state == MEASURE) begin
                if (fail) begin
                    good_cnt  <= '0;
                    frame_bad <= ~vs_fall;
                end else if (vs_fall) begin
                    good_cnt  <= frame_bad ? '0 : good_inc;
                    frame_bad <= 1'b0;
                end
            end else begin
                good_cnt  <= '0;
                frame_bad <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) err <= '0;
        else       err <= (err_clr ? '0 : err) | err_set;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pix_valid  <= 1'b0;
            pix_x      <= '0;
            pix_y      <= '0;
            pix_rgb    <= '0;
            frame_done <= 1'b0;
        end else begin
            pix_valid  <= locked & act_strobe;
            frame_done <= done_now;
            if (locked && act_strobe) begin
                pix_x   <= x_cur;
                pix_y   <= y_cnt;
                pix_rgb <= rgb;
            end
        end
    end

`ifdef VGA_SINK_CHECKSUM_EN
    logic [31:0] sum;

    always_ff @(posedge clk) begin
        if (reset) begin
            sum       <= '0;
            frame_sum <= '0;
        end else begin
            if (vs_fall)         sum <= act_strobe ? {8'h00, rgb} : '0;
            else if (act_strobe) sum <= sum_step(sum, rgb);
            if (done_now) frame_sum <= sum;
        end
    end
`else
    assign frame_sum = '0;
`endif

endmodule
